spi_slave: RTL and testbench

SPI responder for the team's SPI master, at the far end of the same 4-wire link (CS, SCLK, MOSI, MISO). It deserialises MOSI into parallel words and serialises a preloaded word onto MISO in the same frame. The whole block runs in the SCLK domain. Mode 0 framing matches the master:
- Master drives MOSI and CS on SCLK falling edge and samples MISO on rising edge.
- Slave samples MOSI on rising edge and drives MISO on falling edge. MSB first.

---
 rtl/spi_slave.sv | 167 ++++++++++++++++
 tb/tb_spi_slave.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : Mode 0 SPI responder clocked entirely by SCLK. Deserialises
//                MOSI into words, serialises a buffered TX word onto MISO,
//                one-word holding buffer, back-to-back frames while CS low.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave #(
    parameter int DATA_W = 8
) (
    input  logic              sclk_o,
    input  logic              aresetn_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              underrun_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              state_q,        state_d;
    logic [CNT_W-1:0]    bit_cnt_q,      bit_cnt_d;
    // Only DATA_W-1 bits are kept: the final bit comes straight from mosi_i.
    logic [DATA_W-2:0]   rx_shift_q,     rx_shift_d;
    logic [DATA_W-1:0]   tx_shift_q,     tx_shift_d;
    logic [DATA_W-1:0]   tx_buf_q,       tx_buf_d;
    logic                tx_full_q,      tx_full_d;
    logic                tx_shift_vld_q, tx_shift_vld_d;
    logic [DATA_W-1:0]   rx_data_q,      rx_data_d;
    logic                rx_valid_q,     rx_valid_d;
    logic                underrun_q,     underrun_d;
    logic                miso_q;

    logic [DATA_W-1:0]   w_rx_word;
    logic [DATA_W-1:0]   w_tx_next;
    logic                w_last_bit;

    assign w_rx_word  = {rx_shift_q, mosi_i};
    assign w_tx_next  = {tx_shift_q[DATA_W-2:0], 1'b0};
    assign w_last_bit = (bit_cnt_q == CNT_W'(DATA_W - 1));

    // Next-state logic: framing FSM, shift registers and TX holding buffer.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        tx_buf_d       = tx_buf_q;
        tx_full_d      = tx_full_q;
        tx_shift_vld_d = tx_shift_vld_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        underrun_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!cs_i) begin
                    rx_shift_d = w_rx_word[DATA_W-2:0];
                    tx_shift_d = w_tx_next;
                    bit_cnt_d  = CNT_W'(1);
                    underrun_d = !tx_shift_vld_q;
                    state_d    = ST_SHIFT;
                end else if (tx_full_q && !tx_shift_vld_q) begin
                    // Move the buffered word into the shifter so its MSB is
                    // presented on MISO before the first sampling edge.
                    tx_shift_d     = tx_buf_q;
                    tx_shift_vld_d = 1'b1;
                    tx_full_d      = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cs_i) begin
                    // Abort: partial word and unsent TX remainder are dropped.
                    state_d        = ST_IDLE;
                    bit_cnt_d      = '0;
                    tx_shift_d     = '0;
                    tx_shift_vld_d = 1'b0;
                end else begin
                    rx_shift_d = w_rx_word[DATA_W-2:0];
                    tx_shift_d = w_tx_next;
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == '0) begin
                        underrun_d = !tx_shift_vld_q;
                    end
                    if (w_last_bit) begin
                        rx_data_d  = w_rx_word;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        if (tx_full_q) begin
                            tx_shift_d     = tx_buf_q;
                            tx_full_d      = 1'b0;
                            tx_shift_vld_d = 1'b1;
                        end else begin
                            tx_shift_d     = '0;
                            tx_shift_vld_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A write can only land when the buffer is empty, so it never
        // collides with a reload, which needs the buffer full.
        if (tx_valid_i && !tx_full_q) begin
            tx_buf_d  = tx_data_i;
            tx_full_d = 1'b1;
        end
    end

    // Rising-edge state registers with asynchronous active-low reset.
    always_ff @(posedge sclk_o or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            tx_buf_q       <= '0;
            tx_full_q      <= 1'b0;
            tx_shift_vld_q <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            tx_buf_q       <= tx_buf_d;
            tx_full_q      <= tx_full_d;
            tx_shift_vld_q <= tx_shift_vld_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            underrun_q     <= underrun_d;
        end
    end

    // MISO launches on the falling edge so the master samples a stable bit.
    always_ff @(negedge sclk_o or negedge aresetn_i) begin
        if (!aresetn_i) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= tx_shift_q[DATA_W-1];
        end
    end

    assign miso_o     = miso_q;
    assign tx_ready_o = !tx_full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign underrun_o = underrun_q;
    assign busy_o     = (state_q == ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Directed self-checking bench for spi_slave acting as a
//                Mode 0 master: drives CS/MOSI on falling SCLK, samples
//                MISO and status just after rising SCLK.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_slave;

    logic       sclk;
    logic       aresetn;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       underrun;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic       cap_miso [0:15];
    logic       cap_rxv  [0:15];
    logic       cap_und  [0:15];
    logic       cap_rdy  [0:15];
    logic [7:0] cap_rxd  [0:15];

    spi_slave #(.DATA_W(8)) dut (
        .sclk_o     (sclk),
        .aresetn_i  (aresetn),
        .cs_i       (cs),
        .mosi_i     (mosi),
        .miso_o     (miso),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .underrun_o (underrun),
        .busy_o     (busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // One SCLK period: drive after the falling edge, return after rising edge.
    task automatic cyc(input logic c, input logic m, input logic v, input logic [7:0] d);
        @(negedge sclk);
        #1;
        cs       = c;
        mosi     = m;
        tx_valid = v;
        tx_data  = d;
        @(posedge sclk);
        #1;
    endtask

    // Clock n bits with CS low, MSB of the n-bit word first, capturing outputs.
    task automatic run_bits(input int n, input logic [15:0] word);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, word[n-1-i], 1'b0, 8'h00);
            cap_miso[i] = miso;
            cap_rxv[i]  = rx_valid;
            cap_und[i]  = underrun;
            cap_rdy[i]  = tx_ready;
            cap_rxd[i]  = rx_data;
        end
    endtask

    task automatic test_reset;
        aresetn  = 1'b0;
        cs       = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #2;
        checks++; if (miso !== 1'b0)     begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rxv: got %b expected 0", rx_valid); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_und: got %b expected 0", underrun); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rxd: got %h expected 00", rx_data); end
        @(negedge sclk);
        #1 aresetn = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] txw;
        txw = 8'hA5;
        cyc(1'b1, 1'b0, 1'b1, txw);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_after_write: got %b expected 0", tx_ready); end
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_after_xfer: got %b expected 1", tx_ready); end
        run_bits(8, 16'h003C);
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_miso[i] !== txw[7-i]) begin errors++; $display("FAIL t1_miso bit%0d: got %b expected %b", i, cap_miso[i], txw[7-i]); end
            checks++; if (cap_rxv[i] !== (i == 7)) begin errors++; $display("FAIL t1_rxv bit%0d: got %b expected %b", i, cap_rxv[i], (i == 7)); end
            checks++; if (cap_und[i] !== 1'b0) begin errors++; $display("FAIL t1_und bit%0d: got %b expected 0", i, cap_und[i]); end
        end
        checks++; if (cap_rxd[7] !== 8'h3C) begin errors++; $display("FAIL t1_rxd: got %h expected 3c", cap_rxd[7]); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b expected 1", busy); end
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_end: got %b expected 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL t1_rxv_end: got %b expected 0", rx_valid); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] txw;
        txw = 16'h1122;
        cyc(1'b1, 1'b0, 1'b1, 8'h11);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 8'h22);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL t2_ready_full: got %b expected 0", tx_ready); end
        run_bits(16, 16'hF00F);
        for (int i = 0; i < 16; i++) begin
            checks++; if (cap_miso[i] !== txw[15-i]) begin errors++; $display("FAIL t2_miso bit%0d: got %b expected %b", i, cap_miso[i], txw[15-i]); end
            checks++; if (cap_rxv[i] !== (i == 7 || i == 15)) begin errors++; $display("FAIL t2_rxv bit%0d: got %b expected %b", i, cap_rxv[i], (i == 7 || i == 15)); end
            checks++; if (cap_und[i] !== 1'b0) begin errors++; $display("FAIL t2_und bit%0d: got %b expected 0", i, cap_und[i]); end
        end
        checks++; if (cap_rdy[6] !== 1'b0) begin errors++; $display("FAIL t2_ready_bit7: got %b expected 0", cap_rdy[6]); end
        checks++; if (cap_rdy[7] !== 1'b1) begin errors++; $display("FAIL t2_ready_bit8: got %b expected 1", cap_rdy[7]); end
        checks++; if (cap_rxd[7] !== 8'hF0) begin errors++; $display("FAIL t2_rxd0: got %h expected f0", cap_rxd[7]); end
        checks++; if (cap_rxd[15] !== 8'h0F) begin errors++; $display("FAIL t2_rxd1: got %h expected 0f", cap_rxd[15]); end
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_underrun;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        run_bits(8, 16'h0096);
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_miso[i] !== 1'b0) begin errors++; $display("FAIL t3_miso bit%0d: got %b expected 0", i, cap_miso[i]); end
            checks++; if (cap_und[i] !== (i == 0)) begin errors++; $display("FAIL t3_und bit%0d: got %b expected %b", i, cap_und[i], (i == 0)); end
        end
        checks++; if (cap_rxv[7] !== 1'b1) begin errors++; $display("FAIL t3_rxv: got %b expected 1", cap_rxv[7]); end
        checks++; if (cap_rxd[7] !== 8'h96) begin errors++; $display("FAIL t3_rxd: got %h expected 96", cap_rxd[7]); end
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_abort;
        run_bits(5, 16'h0016);
        for (int i = 0; i < 5; i++) begin
            checks++; if (cap_rxv[i] !== 1'b0) begin errors++; $display("FAIL t4_rxv_partial bit%0d: got %b expected 0", i, cap_rxv[i]); end
        end
        checks++; if (cap_und[0] !== 1'b1) begin errors++; $display("FAIL t4_und_partial: got %b expected 1", cap_und[0]); end
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL t4_rxv_abort: got %b expected 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_busy_abort: got %b expected 0", busy); end
        checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL t4_rxd_held: got %h expected 96", rx_data); end
        run_bits(8, 16'h0081);
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_rxv[i] !== (i == 7)) begin errors++; $display("FAIL t4_rxv bit%0d: got %b expected %b", i, cap_rxv[i], (i == 7)); end
        end
        checks++; if (cap_rxd[7] !== 8'h81) begin errors++; $display("FAIL t4_rxd: got %h expected 81", cap_rxd[7]); end
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_buffer_full;
        logic [15:0] txw;
        txw = 16'h5A77;
        cyc(1'b1, 1'b0, 1'b1, 8'h5A);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL t5_ready_empty: got %b expected 1", tx_ready); end
        cyc(1'b1, 1'b0, 1'b1, 8'h77);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL t5_ready_full: got %b expected 0", tx_ready); end
        cyc(1'b1, 1'b0, 1'b1, 8'h99);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL t5_ready_drop: got %b expected 0", tx_ready); end
        run_bits(16, 16'h00FF);
        for (int i = 0; i < 16; i++) begin
            checks++; if (cap_miso[i] !== txw[15-i]) begin errors++; $display("FAIL t5_miso bit%0d: got %b expected %b", i, cap_miso[i], txw[15-i]); end
        end
        checks++; if (cap_rxd[7] !== 8'h00) begin errors++; $display("FAIL t5_rxd0: got %h expected 00", cap_rxd[7]); end
        checks++; if (cap_rxd[15] !== 8'hFF) begin errors++; $display("FAIL t5_rxd1: got %h expected ff", cap_rxd[15]); end
        checks++; if (cap_rdy[15] !== 1'b1) begin errors++; $display("FAIL t5_ready_end: got %b expected 1", cap_rdy[15]); end
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset_midframe;
        cyc(1'b1, 1'b0, 1'b1, 8'hF8);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 8'h12);
        run_bits(4, 16'h000C);
        checks++; if (miso !== 1'b1) begin errors++; $display("FAIL t6_miso_pre: got %b expected 1", miso); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_busy_pre: got %b expected 1", busy); end
        #1 aresetn = 1'b0;
        #1;
        checks++; if (miso !== 1'b0)     begin errors++; $display("FAIL t6_miso_rst: got %b expected 0", miso); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL t6_busy_rst: got %b expected 0", busy); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL t6_ready_rst: got %b expected 1", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL t6_rxd_rst: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL t6_rxv_rst: got %b expected 0", rx_valid); end
        cs = 1'b1;
        tx_valid = 1'b0;
        @(negedge sclk);
        #1 aresetn = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        run_bits(8, 16'h00C3);
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_miso[i] !== 1'b0) begin errors++; $display("FAIL t6_miso bit%0d: got %b expected 0", i, cap_miso[i]); end
            checks++; if (cap_rxv[i] !== (i == 7)) begin errors++; $display("FAIL t6_rxv bit%0d: got %b expected %b", i, cap_rxv[i], (i == 7)); end
        end
        checks++; if (cap_und[0] !== 1'b1) begin errors++; $display("FAIL t6_und: got %b expected 1", cap_und[0]); end
        checks++; if (cap_rxd[7] !== 8'hC3) begin errors++; $display("FAIL t6_rxd: got %h expected c3", cap_rxd[7]); end
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_buffer_full();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
